// File: rtl/waveform_buffer_reader.sv
// Readout stage for the waveform buffer. It pops one header per event, hands the
// header to the formatter, then walks the event's BRAM addresses and streams the
// samples through a small skid FIFO. A read is only issued when the FIFO has room
// for it plus every read still in the BRAM pipeline, so it can never overflow.
//
// Handshakes (header and samples alike): a transfer happens on a cycle where
// valid && ready are both 1. Once valid is raised, it and its payload stay
// unchanged until that transfer.
module waveform_buffer_reader #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_RD_LAT     = 2,
  parameter int P_SKID_DEPTH = 4   // must be >= P_RD_LAT+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_HDR_WIDTH-1:0]  evt_hdr,
  output logic                    evt_hdr_valid,
  input  logic                    evt_hdr_ready,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    eoe_err,
  output logic [15:0]             n_evt_read,
  output logic [1:0]              dbg_state
);

  localparam int PW = (P_SKID_DEPTH > 1) ? $clog2(P_SKID_DEPTH) : 1;
  localparam int CW = $clog2(P_SKID_DEPTH + 1);
  localparam int IW = $clog2(P_SKID_DEPTH + P_RD_LAT + 1);
  localparam logic [P_ADR_WIDTH:0]   REM_ONE = 1;
  localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FETCH, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
  logic [P_ADR_WIDTH:0]    rem_q, rem_d;       // reads still to issue, up to 2^P_ADR_WIDTH
  logic [P_ADR_WIDTH-1:0]  span;
  logic [P_RD_LAT-1:0]     pvld_q, plast_q;    // tags travelling alongside the BRAM pipeline
  logic                    issue, issue_last;
  logic [IW-1:0]           in_flight, occ;

  logic [P_DATA_WIDTH-1:0] skid_data_q [P_SKID_DEPTH];
  logic                    skid_last_q [P_SKID_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    push, push_last, pop;
  logic [15:0]             n_evt_q;
  logic                    eoe_err_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(P_SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign span       = hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH] - hdr_data[P_ADR_WIDTH-1:0];
  assign push       = pvld_q[P_RD_LAT-1];
  assign push_last  = plast_q[P_RD_LAT-1];
  assign dout_valid = (cnt_q != '0);
  assign pop        = dout_valid && dout_ready;
  assign dout       = dout_valid ? skid_data_q[rd_ptr_q] : '0;
  assign dout_last  = dout_valid ? skid_last_q[rd_ptr_q] : 1'b0;

  assign wvb_rd_addr   = addr_q;
  assign evt_hdr       = hdr_q;
  assign evt_hdr_valid = (state_q == S_HDR);
  assign busy          = (state_q != S_IDLE);
  assign eoe_err       = eoe_err_q;
  assign n_evt_read    = n_evt_q;
  assign dbg_state     = state_q;

  // Credit accounting: reads in the BRAM pipeline plus words parked in the skid FIFO.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < P_RD_LAT; i++) in_flight = in_flight + IW'(pvld_q[i]);
    occ = in_flight + IW'(cnt_q);
  end

  // Next-state logic for the event walk, plus the header pop and read issue strobes.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    hdr_rdreq  = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        // No pop while in reset, otherwise the header would be lost silently.
        if (en && !hdr_empty && !rst) begin
          hdr_rdreq = 1'b1;
          hdr_d     = hdr_data;
          addr_d    = hdr_data[P_ADR_WIDTH-1:0];
          rem_d     = {1'b0, span} + REM_ONE;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (evt_hdr_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (occ < IW'(P_SKID_DEPTH)) begin
          issue  = 1'b1;
          addr_d = addr_q + ADR_ONE;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (in_flight == '0 && cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read pipeline tags, skid FIFO bookkeeping and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hdr_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      pvld_q    <= '0;
      plast_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      n_evt_q   <= '0;
      eoe_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pvld_q[0]  <= issue;
      plast_q[0] <= issue_last;
      for (int i = 1; i < P_RD_LAT; i++) begin
        pvld_q[i]  <= pvld_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
      if (pop && dout_last) n_evt_q <= n_evt_q + 16'd1;
      // The eoe flag must be set on the last word and only there.
      if (push && (push_last != wvb_data[0])) eoe_err_q <= 1'b1;
    end
  end

  // Skid FIFO storage; occupancy is tracked above, so the contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      skid_data_q[wr_ptr_q] <= wvb_data;
      skid_last_q[wr_ptr_q] <= push_last;
    end
  end

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Bench for waveform_buffer_reader: header FIFO and 2-cycle BRAM models, directed
// events, and a scoreboard whose monitor checks every header and sample transfer.
module tb_waveform_buffer_reader;

  localparam int DW = 22;
  localparam int AW = 12;
  localparam int HW = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          hdr_empty = 1'b1;
  logic [HW-1:0] hdr_data = '0;
  logic          hdr_rdreq;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_data = '0;
  logic [HW-1:0] evt_hdr;
  logic          evt_hdr_valid;
  logic          evt_hdr_ready = 1'b1;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          busy;
  logic          eoe_err;
  logic [15:0]   n_evt_read;
  logic [1:0]    dbg_state;

  waveform_buffer_reader dut (
    .clk(clk), .rst(rst), .en(en),
    .hdr_empty(hdr_empty), .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq),
    .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data),
    .evt_hdr(evt_hdr), .evt_hdr_valid(evt_hdr_valid), .evt_hdr_ready(evt_hdr_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .eoe_err(eoe_err), .n_evt_read(n_evt_read), .dbg_state(dbg_state)
  );

  // ---------------- models ----------------
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] bram_s1 = '0;
  always @(posedge clk) begin
    bram_s1  <= mem[wvb_rd_addr];
    wvb_data <= bram_s1;
  end

  logic [HW-1:0] hq[$];
  int  pops = 0;
  bit  rd_seen = 0;
  always @(negedge clk) rd_seen = hdr_rdreq;
  always @(posedge clk) begin
    #1;
    if (rd_seen) begin
      if (hq.size() > 0) begin
        void'(hq.pop_front());
        pops++;
      end
      rd_seen = 0;
    end
    hdr_empty = (hq.size() == 0);
    hdr_data  = hdr_empty ? '0 : hq[0];
  end

  int rdy_mode = 0;
  int stall = 0;
  initial forever begin
    @(posedge clk); #1;
    if (stall > 0) begin
      dout_ready = 1'b0;
      stall--;
    end else if (rdy_mode == 1) dout_ready = ~dout_ready;
    else dout_ready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];      // {last, word}
  logic [HW-1:0] exp_hdr_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  logic [DW:0] held = '0;
  bit          hold_pend = 0;
  logic [7:0]  cur_id = '0;
  always @(negedge clk) begin
    if (rst) hold_pend = 0;
    else if (hold_pend) chk("hold_stable", {dout_valid, dout_last, dout}, {1'b1, held});
    hold_pend = !rst && dout_valid && !dout_ready;
    held = {dout_last, dout};
    if (evt_hdr_valid && evt_hdr_ready) begin
      if (exp_hdr_q.size() == 0) fail_now("hdr_unexpected");
      else chk("evt_hdr", evt_hdr, exp_hdr_q.pop_front());
      cur_id = evt_hdr[79:72];
    end
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) fail_now("dout_unexpected");
      else chk("dout", {dout_last, dout}, exp_q.pop_front());
      chk("dout_after_hdr", dout[20:13], cur_id);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [HW-1:0] mk_hdr(input logic [7:0] id, input logic [AW-1:0] start,
                                           input logic [AW-1:0] stop);
    return {id, 48'h1234_5678_9ABC, stop, start};
  endfunction

  function automatic logic [DW-1:0] mk_word(input logic [7:0] id, input logic [AW-1:0] a,
                                            input logic eoe);
    return {1'b0, id, a, eoe};
  endfunction

  task automatic load_event(input logic [7:0] id, input logic [AW-1:0] start,
                            input logic [AW-1:0] stop, input int bad_idx, input bit push_hdr);
    logic [AW-1:0] span;
    logic [AW-1:0] a;
    logic          is_last;
    int n;
    span = stop - start;
    n = int'(span) + 1;
    for (int k = 0; k < n; k++) begin
      a = start + AW'(k);
      is_last = (k == n - 1);
      mem[a] = mk_word(id, a, is_last ^ (k == bad_idx));
      exp_q.push_back({is_last, mem[a]});
    end
    exp_hdr_q.push_back(mk_hdr(id, start, stop));
    if (push_hdr) hq.push_back(mk_hdr(id, start, stop));
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && exp_hdr_q.size() == 0 && hq.size() == 0) break;
    end
    if (c == 600) fail_now({tag, "_timeout"});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hdr_rdreq"}, HW'(hdr_rdreq), '0);
    chk({tag, "_rd_addr"}, HW'(wvb_rd_addr), '0);
    chk({tag, "_evt_hdr"}, evt_hdr, '0);
    chk({tag, "_hdr_valid"}, HW'(evt_hdr_valid), '0);
    chk({tag, "_dout"}, HW'({dout_valid, dout_last, dout}), '0);
    chk({tag, "_busy"}, HW'(busy), '0);
    chk({tag, "_eoe_err"}, HW'(eoe_err), '0);
    chk({tag, "_n_evt"}, HW'(n_evt_read), '0);
    chk({tag, "_state"}, HW'(dbg_state), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single event with the header held off for a while.
    evt_hdr_ready = 1'b0;
    load_event(8'd1, 12'h010, 12'h013, -1, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t1_hdr_valid_held", HW'(evt_hdr_valid), HW'(1));
    chk("t1_no_dout_before_hdr", HW'(dout_valid), '0);
    chk("t1_one_pop", HW'(pops), HW'(1));
    chk("t1_busy", HW'(busy), HW'(1));
    @(posedge clk); #1;
    evt_hdr_ready = 1'b1;
    wait_idle("t1");
    chk("t1_n_evt", HW'(n_evt_read), HW'(1));
    chk("t1_eoe_err", HW'(eoe_err), '0);

    // Address wrap.
    load_event(8'd2, 12'hFFE, 12'h001, -1, 1);
    wait_idle("t2");
    chk("t2_n_evt", HW'(n_evt_read), HW'(2));

    // Backpressure: toggling ready, a 10-cycle stall, and en dropped mid-event.
    rdy_mode = 1;
    load_event(8'd3, 12'h300, 12'h30F, -1, 1);
    repeat (8) @(posedge clk); #1;
    stall = 10;
    en = 1'b0;
    wait_idle("t3");
    rdy_mode = 0;
    en = 1'b1;
    chk("t3_n_evt", HW'(n_evt_read), HW'(3));

    // Back-to-back events, the last one a single sample.
    load_event(8'd4, 12'h400, 12'h402, -1, 1);
    load_event(8'd5, 12'h410, 12'h417, -1, 1);
    load_event(8'd6, 12'h420, 12'h420, -1, 1);
    wait_idle("t4");
    chk("t4_n_evt", HW'(n_evt_read), HW'(6));
    chk("t4_pops", HW'(pops), HW'(6));
    chk("t4_busy", HW'(busy), '0);

    // Framing error on a middle word, then a clean event: flag stays set.
    load_event(8'd7, 12'h500, 12'h504, 2, 1);
    wait_idle("t5");
    chk("t5_eoe_err_set", HW'(eoe_err), HW'(1));
    load_event(8'd8, 12'h510, 12'h511, -1, 1);
    wait_idle("t5b");
    chk("t5_eoe_err_sticky", HW'(eoe_err), HW'(1));
    chk("t5_n_evt", HW'(n_evt_read), HW'(8));

    // en=0 in IDLE: a queued header must wait.
    @(posedge clk); #1;
    en = 1'b0;
    load_event(8'd9, 12'h600, 12'h602, -1, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("en0_no_pop", HW'(pops), HW'(8));
    chk("en0_idle", HW'(dbg_state), '0);
    @(posedge clk); #1;
    en = 1'b1;
    wait_idle("en1");
    chk("en1_n_evt", HW'(n_evt_read), HW'(9));

    // Reset in the middle of a 100-word event with another header queued behind it.
    load_event(8'd10, 12'h100, 12'h163, -1, 1);
    hq.push_back(mk_hdr(8'd11, 12'h200, 12'h205));
    repeat (30) @(posedge clk); #1;
    chk("rst_mid_state_fetch", HW'(dbg_state), HW'(2));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    chk("rst_mid_pops", HW'(pops), HW'(10));
    exp_q.delete();
    exp_hdr_q.delete();
    load_event(8'd11, 12'h200, 12'h205, -1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle("after_rst");
    chk("after_rst_n_evt", HW'(n_evt_read), HW'(1));
    chk("after_rst_eoe", HW'(eoe_err), '0);
    chk("after_rst_pops", HW'(pops), HW'(11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/waveform_buffer_reader.md
Name: waveform_buffer_reader

Overview:
Readout stage directly downstream of the waveform buffer storage block. It pops one header per event from the header FIFO and walks the event's sample addresses in the waveform BRAM. It streams the header, then the samples, to the readout formatter over valid/ready handshakes. It absorbs BRAM read latency and formatter backpressure with a credit-limited skid FIFO.

Parameters:
P_DATA_WIDTH, 22, waveform word width; bit 0 is the end-of-event (eoe) flag
P_ADR_WIDTH, 12, waveform buffer address width
P_HDR_WIDTH, 80, header width
P_RD_LAT, 2, BRAM read latency in cycles, from wvb_rd_addr to wvb_data
P_SKID_DEPTH, 4, skid FIFO depth; must be >= P_RD_LAT+1

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
en  in  1  allows new events to start
hdr_empty  in  1  header FIFO empty
hdr_data  in  P_HDR_WIDTH  header FIFO output; first-word-fall-through
hdr_rdreq  out  1  header FIFO pop
wvb_rd_addr  out  P_ADR_WIDTH  BRAM read address
wvb_data  in  P_DATA_WIDTH  BRAM read data
evt_hdr  out  P_HDR_WIDTH  latched header of the current event
evt_hdr_valid  out  1  header handshake valid
evt_hdr_ready  in  1  header handshake ready
dout  out  P_DATA_WIDTH  sample word, eoe in bit 0
dout_valid  out  1  sample valid
dout_ready  in  1  sample ready
dout_last  out  1  final sample of the event
busy  out  1  event in progress
eoe_err  out  1  sticky eoe framing error
n_evt_read  out  16  completed-event counter; wraps

Behaviour:
- Header field layout: start_addr = hdr[P_ADR_WIDTH-1:0]; stop_addr = hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH]. All remaining bits are opaque and passed through.
- Reset: all outputs go to 0, the FSM enters IDLE, and the skid FIFO and read pipeline are flushed. If reset hits mid-event, the event is abandoned; its header is already popped and is not replayed.
- FSM states: IDLE -> HDR -> FETCH -> DRAIN -> IDLE.
- IDLE: when en=1 and hdr_empty=0:
  - latch hdr_data into evt_hdr;
  - pulse hdr_rdreq for exactly 1 cycle;
  - load addr=start_addr and remaining = ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1;
  - go to HDR.
  - stop_addr == start_addr gives a 1-sample event.
- HDR: evt_hdr_valid=1 starting the cycle after the pop, held until evt_hdr_ready=1. Transfer completes on valid&&ready, then go to FETCH.
- FETCH:
  - Issue one read per cycle when (in_flight + skid_count) < P_SKID_DEPTH.
  - wvb_rd_addr = addr; addr increments modulo 2^P_ADR_WIDTH, so the wrap from all-ones to 0 is seamless.
  - A P_RD_LAT-deep valid/last shift register tags each issued read; the data is pushed into the skid FIFO P_RD_LAT cycles after issue.
  - The final issued address carries the last tag. After issuing it, go to DRAIN.
- DRAIN: wait until in_flight=0 and the skid FIFO is empty with the last word accepted, then go to IDLE.
  - n_evt_read increments on the cycle the last word is accepted.
- Output stream:
  - dout/dout_valid/dout_last come from the skid FIFO head; a word transfers on dout_valid && dout_ready.
  - dout_valid may be asserted in the same cycle as evt_hdr_valid acceptance plus P_RD_LAT at the earliest; it is never asserted before the header transfers.
  - dout and dout_last are held stable while dout_valid=1 and dout_ready=0.
  - Backpressure never loses or duplicates a word; the credit rule guarantees the skid FIFO never overflows.
- Throughput: with dout_ready held at 1, a sustained 1 word/cycle.
- eoe_err: set sticky (cleared only by rst) if the last word has bit0=0, or any non-last word has bit0=1. Data is still forwarded unchanged.
- busy = 1 in any state other than IDLE, and stays 1 until the DRAIN exit.
- en=0 mid-event: the current event completes; no new event starts.
- IDLE with hdr_empty=1: no pop and no reads are issued.

Test Plan:
- Single event, start=0x010, stop=0x013, dout_ready=1 -> one hdr_rdreq pulse; header transferred; 4 words from addresses 0x010-0x013 in order; dout_last on the 4th; n_evt_read=1; eoe_err=0.
- Wrap event, start=0xFFE, stop=0x001 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; 4 words; last on the word from 0x001.
- Backpressure: 16-word event with dout_ready toggled 1/0 each cycle plus a 10-cycle stall -> all 16 words exactly once, in order; data stable during stalls; skid occupancy <= P_SKID_DEPTH.
- Back-to-back: 3 headers queued, evt_hdr_ready=1, dout_ready=1 -> 3 pops, 3 headers each preceding their samples, n_evt_read=3, busy=0 at the end.
- Framing error: eoe bit set on word 2 of a 5-word event -> eoe_err=1 and stays 1; all 5 words still delivered.
- Reset mid-FETCH of a 100-word event -> next cycle all outputs 0 and state IDLE; the following queued event reads correctly.
